// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

    localparam int INSN_BYTES = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order instruction queue between fetch and decode
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail
//   push_data    entry to enqueue
//   pop          retire the head entry
//   flush        empty the queue and reset both pointers (wins over push/pop)
//   count        number of valid entries
//   head         entry at the head of the queue
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count_q == CW'(DEPTH)));

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch PC owner driving the icache with one outstanding request
//
// Ports:
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   fetch_enable            permits new cache requests
//   redirect_valid/_pc      single-cycle redirect strobe and target (bits [1:0] ignored)
//   ic_addr/ic_req          cache request address and request
//   ic_data/ic_ready        cache read data and ready (response = ic_req && ic_ready)
//   inst_valid/_data/_pc    queue head towards decode
//   inst_ready              decode accepts the head
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        fetch_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ic_addr,
    output logic        ic_req,
    input  logic [31:0] ic_data,
    input  logic        ic_ready,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pending_pc_q, pending_pc_d;

    logic [31:0]  redir_target;
    logic         unused_redirect_lsbs;
    logic         resp, push, pop, flush, can_issue;
    logic [CW-1:0] count, count_next;
    iq_entry_t    push_entry, head_entry;

    assign redir_target         = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign ic_addr = pc_q;
    assign ic_req  = (state_q != IDLE);
    assign resp    = ic_req && ic_ready;

    // Only a clean response in REQ is kept; anything arriving with or after
    // a redirect belongs to the abandoned path.
    assign push  = (state_q == REQ) && resp && !redirect_valid;
    assign pop   = inst_valid && inst_ready;
    assign flush = redirect_valid;

    assign push_entry.data = ic_data;
    assign push_entry.pc   = pc_q;

    // Issue only when a slot is guaranteed for the response, so the queue
    // cannot overflow while the request is in flight.
    assign count_next = flush ? '0 : count + CW'(push) - CW'(pop);
    assign can_issue  = fetch_enable && (count_next < DEPTH_C);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        case (state_q)
            IDLE: begin
                if (redirect_valid) pc_d = redir_target;
                if (can_issue) state_d = REQ;
            end
            REQ: begin
                if (resp && !redirect_valid) begin
                    pc_d    = pc_q + 32'(INSN_BYTES);
                    state_d = can_issue ? REQ : IDLE;
                end else if (resp) begin
                    pc_d    = redir_target;
                    state_d = fetch_enable ? REQ : IDLE;
                end else if (redirect_valid) begin
                    // Address must stay stable until the cache answers.
                    pending_pc_d = redir_target;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                if (redirect_valid) pending_pc_d = redir_target;
                if (resp) begin
                    pc_d    = redirect_valid ? redir_target : pending_pc_q;
                    state_d = fetch_enable ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pending_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH ($bits(iq_entry_t))
    ) u_queue (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head      (head_entry)
    );

    assign inst_valid = (count != '0);
    assign inst_data  = head_entry.data;
    assign inst_pc    = head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        fetch_enable, redirect_valid, ic_req, ic_ready, inst_valid, inst_ready;
    logic [31:0] redirect_pc, ic_addr, ic_data, inst_data, inst_pc;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    exp_t        sb[$];
    logic [31:0] kept_log[$];
    int          kept_cyc[$];
    logic [31:0] resp_log[$];
    logic [31:0] pop_log[$];

    logic [31:0] model_pc, pending, redir_target;
    logic        busy, tainted, fe, rdy_in, miss_hold, redir_now, redir_on_resp;
    int          wait_cnt;

    instruction_fetch_unit #(
        .RESET_PC    (32'h100),
        .QUEUE_DEPTH (4)
    ) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .fetch_enable   (fetch_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ic_addr        (ic_addr),
        .ic_req         (ic_req),
        .ic_data        (ic_data),
        .ic_ready       (ic_ready),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check settled state, drive inputs and cache model, update the
    // scoreboard, then cross the rising edge.
    task automatic tick();
        logic        resp, pop;
        logic [31:0] tgt;
        exp_t        e;
        @(negedge HCLK);
        cyc++;
        chk_eq("addr", ic_addr, model_pc);
        chk_eq("valid", inst_valid, sb.size() != 0);
        fetch_enable   = fe;
        inst_ready     = rdy_in;
        redirect_valid = redir_now;
        redirect_pc    = redir_target;
        redir_now      = 1'b0;
        if (ic_req) begin
            if (!busy) begin
                busy     = 1'b1;
                wait_cnt = 1;
            end
            if (miss_hold) ic_ready = 1'b0;
            else if (wait_cnt != 0) begin
                ic_ready = 1'b0;
                wait_cnt--;
            end else ic_ready = 1'b1;
        end else begin
            ic_ready = 1'b1;
        end
        ic_data = ~ic_addr;
        if (redir_on_resp && ic_req && ic_ready) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_target;
            redir_on_resp  = 1'b0;
        end
        #1;
        resp = ic_req && ic_ready;
        pop  = inst_valid && inst_ready;
        tgt  = redirect_pc & 32'hFFFF_FFFC;
        if (pop) begin
            if (sb.size() == 0) chk_eq("pop_empty", 1, 0);
            else begin
                e = sb.pop_front();
                chk_eq("inst_pc", inst_pc, e.pc);
                chk_eq("inst_data", inst_data, e.data);
                pop_log.push_back(inst_pc);
            end
        end
        if (redirect_valid) sb.delete();
        if (resp) begin
            resp_log.push_back(ic_addr);
            busy = 1'b0;
            if (!redirect_valid && !tainted) begin
                sb.push_back('{data: ~model_pc, pc: model_pc});
                kept_log.push_back(model_pc);
                kept_cyc.push_back(cyc);
                model_pc = model_pc + 32'd4;
            end else if (redirect_valid) model_pc = tgt;
            else model_pc = pending;
            tainted = 1'b0;
        end else if (redirect_valid) begin
            if (ic_req) begin
                tainted = 1'b1;
                pending = tgt;
            end else model_pc = tgt;
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_kept(input string tag, input int n);
        int g = 0;
        while (kept_log.size() < n && g < 100) begin
            tick();
            g++;
        end
        chk_eq(tag, kept_log.size() >= n, 1);
    endtask

    // Stop fetching, drain the queue, redirect from IDLE and resume.
    task automatic restart(input logic [31:0] target);
        int g = 0;
        fe = 1'b0;
        rdy_in = 1'b1;
        miss_hold = 1'b0;
        while (ic_req && g < 100) begin
            tick();
            g++;
        end
        chk_eq("restart_idle", ic_req, 0);
        repeat (6) tick();
        redir_now = 1'b1;
        redir_target = target;
        tick();
        kept_log.delete();
        kept_cyc.delete();
        resp_log.delete();
        pop_log.delete();
        fe = 1'b1;
    endtask

    initial begin
        int g, n, bad;
        HRESETn = 1'b0;
        fetch_enable = 0; redirect_valid = 0; redirect_pc = 0;
        ic_ready = 0; ic_data = 0; inst_ready = 0;
        fe = 0; rdy_in = 0; miss_hold = 0; redir_now = 0; redir_on_resp = 0;
        redir_target = 0; busy = 0; tainted = 0; wait_cnt = 0;
        model_pc = 32'h100; pending = 0;
        repeat (2) @(negedge HCLK);
        chk_eq("rst_ic_req", ic_req, 0);
        chk_eq("rst_inst_valid", inst_valid, 0);
        chk_eq("rst_ic_addr", ic_addr, 32'h100);
        HRESETn = 1'b1;

        // Sequential hits: one instruction every two cycles.
        fe = 1; rdy_in = 1;
        wait_kept("t1_wait", 3);
        chk_eq("t1_addr0", kept_log[0], 32'h100);
        chk_eq("t1_addr1", kept_log[1], 32'h104);
        chk_eq("t1_addr2", kept_log[2], 32'h108);
        chk_eq("t1_gap0", kept_cyc[1] - kept_cyc[0], 2);
        chk_eq("t1_gap1", kept_cyc[2] - kept_cyc[1], 2);

        // Back-pressure: exactly QUEUE_DEPTH responses, then one per freed slot.
        restart(32'h100);
        rdy_in = 0;
        repeat (20) tick();
        chk_eq("t2_count", kept_log.size(), 4);
        chk_eq("t2_req_off", ic_req, 0);
        chk_eq("t2_addr", ic_addr, 32'h110);
        rdy_in = 1;
        tick();
        rdy_in = 0;
        repeat (12) tick();
        chk_eq("t2_count2", kept_log.size(), 5);
        chk_eq("t2_addr110", kept_log[kept_log.size()-1], 32'h110);
        chk_eq("t2_req_off2", ic_req, 0);

        // Redirect while a miss is outstanding.
        restart(32'h100);
        wait_kept("t3_wait", 1);
        miss_hold = 1;
        repeat (2) tick();
        redir_now = 1; redir_target = 32'h2002;
        tick();
        repeat (3) begin
            tick();
            chk_eq("t3_hold_addr", ic_addr, 32'h104);
            chk_eq("t3_hold_req", ic_req, 1);
        end
        miss_hold = 0;
        n = resp_log.size();
        g = 0;
        while (resp_log.size() == n && g < 50) begin
            tick();
            g++;
        end
        chk_eq("t3_resp_seen", resp_log.size() > n, 1);
        chk_eq("t3_discard", kept_log.size(), 1);
        chk_eq("t3_empty", inst_valid, 0);
        chk_eq("t3_next_addr", ic_addr, 32'h2000);
        wait_kept("t3_wait2", 2);
        chk_eq("t3_kept", kept_log[1], 32'h2000);

        // Redirect in the same cycle as the response for 0x104.
        restart(32'h100);
        wait_kept("t4_wait", 1);
        redir_on_resp = 1; redir_target = 32'h300;
        g = 0;
        while (redir_on_resp && g < 50) begin
            tick();
            g++;
        end
        chk_eq("t4_resp_addr", resp_log[resp_log.size()-1], 32'h104);
        chk_eq("t4_no_push", kept_log.size(), 1);
        chk_eq("t4_next_addr", ic_addr, 32'h300);
        pop_log.delete();
        g = 0;
        while (pop_log.size() == 0 && g < 50) begin
            tick();
            g++;
        end
        chk_eq("t4_pop_seen", pop_log.size() != 0, 1);
        chk_eq("t4_first_pc", pop_log[0], 32'h300);

        // Two redirects during one DRAIN: the latest wins.
        restart(32'h100);
        wait_kept("t5_wait", 1);
        miss_hold = 1;
        tick();
        redir_now = 1; redir_target = 32'h400;
        tick();
        tick();
        redir_now = 1; redir_target = 32'h500;
        tick();
        tick();
        miss_hold = 0;
        n = kept_log.size();
        wait_kept("t5_wait2", n + 2);
        chk_eq("t5_resume", kept_log[n], 32'h500);
        chk_eq("t5_next", kept_log[n+1], 32'h504);
        bad = 0;
        foreach (kept_log[i]) if (kept_log[i][31:8] == 24'h4) bad++;
        chk_eq("t5_no_400", bad, 0);

        // Address wrap.
        restart(32'hFFFF_FFFC);
        wait_kept("t6_wait", 2);
        chk_eq("t6_last", kept_log[0], 32'hFFFF_FFFC);
        chk_eq("t6_wrap", kept_log[1], 32'h0);

        // Asynchronous reset in the middle of a request.
        rdy_in = 0;
        repeat (4) tick();
        g = 0;
        while (!ic_req && g < 20) begin
            tick();
            g++;
        end
        chk_eq("t7_pre_req", ic_req, 1);
        chk_eq("t7_pre_valid", inst_valid, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk_eq("t7_req", ic_req, 0);
        chk_eq("t7_valid", inst_valid, 0);
        chk_eq("t7_addr", ic_addr, 32'h100);
        sb.delete();
        model_pc = 32'h100; busy = 0; tainted = 0;
        kept_log.delete();
        kept_cyc.delete();
        @(negedge HCLK);
        HRESETn = 1'b1;
        fe = 1; rdy_in = 1;
        wait_kept("t7_wait", 1);
        chk_eq("t7_restart", kept_log[0], 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch front end that sits directly upstream of the instruction cache controller. It owns the fetch PC and drives the cache CPU-side request interface with one outstanding request at a time. Returned words are buffered, each with its PC, in a small in-order queue that feeds decode. Redirects (branch, jump, trap) flush the queue and restart fetch; an in-flight cache request is always allowed to complete with a stable address.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
QUEUE_DEPTH, 4, instruction queue entries; power of two, at least 2.

Ports:
HCLK  in  1  clock; all state updates on the rising edge.
HRESETn  in  1  asynchronous, active-low reset.
fetch_enable  in  1  permits new cache requests to be issued.
redirect_valid  in  1  single-cycle redirect strobe.
redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
ic_addr  out  32  cache request address (cpu_addr).
ic_req  out  1  cache request (cpu_req).
ic_data  in  32  cache read data (cpu_data); valid when ic_req && ic_ready.
ic_ready  in  1  cache ready (cpu_ready).
inst_valid  out  1  queue head is valid.
inst_data  out  32  queue head instruction.
inst_pc  out  32  queue head PC.
inst_ready  in  1  decode accepts the head.

Behaviour:
- Reset (asynchronous): state=IDLE, pc_q=RESET_PC, pending_pc=0, queue count=0, ic_req=0, inst_valid=0, ic_addr=RESET_PC.
- Combinational outputs: ic_addr = pc_q; ic_req = (state != IDLE).
- A response occurs when ic_req && ic_ready. ic_ready is ignored when ic_req=0.
- can_issue = fetch_enable && count_next < QUEUE_DEPTH, where count_next is the count after this cycle's push, pop and flush.
- States:
  - IDLE: if can_issue, go to REQ. A redirect updates pc_q <= redirect_pc.
  - REQ:
    - Response without redirect: push {ic_data, pc_q}; pc_q <= pc_q+4 (wraps modulo 2^32). Stay in REQ if can_issue, otherwise go to IDLE. This allows back-to-back requests: ic_req stays high and ic_addr changes at the edge.
    - Response with redirect: discard the data; flush; pc_q <= redirect_pc; go to REQ if fetch_enable, otherwise IDLE.
    - Redirect without response: flush; pending_pc <= redirect_pc; go to DRAIN. pc_q is held so ic_addr stays stable.
    - Neither: hold all state.
  - DRAIN: ic_req=1 and ic_addr=pc_q are held. A further redirect overwrites pending_pc (latest wins) and flushes again. On response: discard the data; pc_q <= pending_pc, or redirect_pc if a redirect occurs in the same cycle; go to REQ if fetch_enable, otherwise IDLE.
- Deasserting fetch_enable never aborts an outstanding request. The request completes, the word is pushed unless discarded, and the block returns to IDLE.
- Queue:
  - inst_valid = (count != 0). inst_data and inst_pc come from the head.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Flush sets count=0 and resets the pointers. Flush wins over a same-cycle push and pop; the popped head is still considered consumed.
  - Overflow cannot occur because can_issue reserves a slot. Pushing while full is an assertion failure.
- Latency: redirect to first inst_valid is at least 3 cycles on a cache hit. Sustained hit throughput is one instruction per 2 cycles, because the cache returns through IDLE.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {IDLE, REQ, DRAIN}, localparam INSN_BYTES=4, and the instruction queue entry struct {data, pc}.
- Sub-module fetch_queue: synchronous FIFO with depth and width parameters, push/pop/flush inputs, and count/head outputs. The top level holds the FSM, pc_q and pending_pc.

Test Plan:
- Reset with RESET_PC=32'h100, fetch_enable=1, cache model hits in 1 cycle, inst_ready=1 -> ic_addr sequence 0x100, 0x104, 0x108; inst_pc matches; one instruction every 2 cycles.
- inst_ready=0 and QUEUE_DEPTH=4 -> exactly 4 responses pushed, then ic_req=0; raise inst_ready for 1 cycle -> exactly one new request, to address 0x110.
- Redirect to 0x2002 while a miss is outstanding at 0x104 -> ic_addr held at 0x104 until ic_ready; that word is discarded; queue empty; next ic_addr=0x2000.
- Redirect to 0x300 in the same cycle as the response for 0x104 -> no push; next ic_addr=0x300; the first inst_pc delivered is 0x300.
- Two redirects (0x400, then 0x500) during one DRAIN -> fetch resumes at 0x500, and no word from 0x400 ever appears.
- pc_q=32'hFFFF_FFFC response -> next ic_addr=0x0; HRESETn asserted mid-REQ -> ic_req=0 and inst_valid=0 immediately, ic_addr=RESET_PC.
